// File: rtl/itl_pkg.sv
// Shared definitions for the interleaver address sequencer: widths, FSM states
// and the link table (base offset and block length per link ID).
package itl_pkg;

  localparam int A_WIDTH  = 16;
  localparam int ID_WIDTH = 6;
  localparam int LINK_MIN = 4;
  localparam int LINK_MAX = 29;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Same table feeds the ROM content generator; keep the two in lockstep.
  localparam logic [15:0] LINK_BASE [LINK_MIN:LINK_MAX] = '{
    16'd0,     16'd952,   16'd1240,  16'd1912,  16'd2968,  16'd3160,  16'd3608,
    16'd4312,  16'd4744,  16'd5716,  16'd7012,  16'd7908,  16'd9924,
    16'd12612, 16'd14484, 16'd18516, 16'd24132, 16'd24228, 16'd24964,
    16'd28084, 16'd32628, 16'd36416, 16'd41192, 16'd46648, 16'd52680, 16'd57960
  };

  localparam logic [15:0] LINK_LEN [LINK_MIN:LINK_MAX] = '{
    16'd952,   16'd288,   16'd672,   16'd1056,  16'd192,   16'd448,   16'd704,
    16'd432,   16'd972,   16'd1296,  16'd896,   16'd2016,  16'd2688,
    16'd1872,  16'd4032,  16'd5616,  16'd96,    16'd736,   16'd3120,
    16'd4544,  16'd3788,  16'd4776,  16'd5456,  16'd6032,  16'd5280,  16'd5552
  };

endpackage

// File: rtl/itl_link_lut.sv
// Combinational link ID decode: ROM base offset, block length and a
// supported flag. IDs outside the table decode to zero with supported=0.
module itl_link_lut #(
  parameter int A_WIDTH  = 16,
  parameter int ID_WIDTH = 6
) (
  input  logic [ID_WIDTH-1:0] link_id,
  output logic [A_WIDTH-1:0]  base,
  output logic [A_WIDTH-1:0]  len,
  output logic                supported
);
  import itl_pkg::*;

  always_comb begin
    base      = '0;
    len       = '0;
    supported = 1'b0;
    for (int i = LINK_MIN; i <= LINK_MAX; i++) begin
      if (link_id == ID_WIDTH'(i)) begin
        base      = A_WIDTH'(LINK_BASE[i]);
        len       = A_WIDTH'(LINK_LEN[i]);
        supported = 1'b1;
      end
    end
  end

endmodule

// File: rtl/itl_addr_gen.sv
// Address sequencer for the external interleaver ROM: walks waddr 0..len-1 and
// emits valid/last flags aligned with the ROM's registered itl_addr output.
module itl_addr_gen #(
  parameter int A_WIDTH  = 16,
  parameter int ID_WIDTH = 6
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [ID_WIDTH-1:0] link_id,
  input  logic                abort,
  output logic [A_WIDTH-1:0]  waddr,
  output logic [A_WIDTH-1:0]  id_jump,
  output logic                itl_vld,
  output logic                itl_last,
  input  logic                itl_rdy,
  output logic                busy,
  output logic                done,
  output logic                err
);
  import itl_pkg::*;

  state_t               state_reg;
  logic [A_WIDTH-1:0]   waddr_reg;
  logic [A_WIDTH-1:0]   id_jump_reg;
  logic [A_WIDTH-1:0]   len_m1_reg;
  logic                 a_vld_reg;
  logic                 itl_vld_reg;
  logic                 itl_last_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic [A_WIDTH-1:0]   lut_base;
  logic [A_WIDTH-1:0]   lut_len;
  logic                 lut_ok;
  logic                 adv;
  logic                 at_end;

  itl_link_lut #(
    .A_WIDTH  (A_WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_lut (
    .link_id   (link_id),
    .base      (lut_base),
    .len       (lut_len),
    .supported (lut_ok)
  );

  // The ROM register and the flag registers advance together, so a stall
  // freezes address, data and flags as one unit.
  assign adv    = !itl_vld_reg || itl_rdy;
  assign at_end = (waddr_reg == len_m1_reg);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_IDLE;
      waddr_reg    <= '0;
      id_jump_reg  <= '0;
      len_m1_reg   <= '0;
      a_vld_reg    <= 1'b0;
      itl_vld_reg  <= 1'b0;
      itl_last_reg <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (abort) begin
        state_reg    <= ST_IDLE;
        a_vld_reg    <= 1'b0;
        itl_vld_reg  <= 1'b0;
        itl_last_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (lut_ok) begin
                state_reg   <= ST_RUN;
                id_jump_reg <= lut_base;
                len_m1_reg  <= lut_len - 1'b1;
                waddr_reg   <= '0;
                a_vld_reg   <= 1'b1;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (adv) begin
              itl_vld_reg  <= a_vld_reg;
              itl_last_reg <= a_vld_reg && at_end;
              if (!at_end) begin
                waddr_reg <= waddr_reg + 1'b1;
              end else begin
                a_vld_reg <= 1'b0;
                state_reg <= ST_FLUSH;
              end
            end
          end
          ST_FLUSH: begin
            if (itl_vld_reg && itl_last_reg && itl_rdy) begin
              state_reg    <= ST_IDLE;
              itl_vld_reg  <= 1'b0;
              itl_last_reg <= 1'b0;
              done_reg     <= 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign waddr    = waddr_reg;
  assign id_jump  = id_jump_reg;
  assign itl_vld  = itl_vld_reg;
  assign itl_last = itl_last_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_itl_addr_gen.sv
// Directed bench for itl_addr_gen with a behavioural ROM attached to
// waddr+id_jump; link blocks come from a vector table plus corner sequences.
module tb_itl_addr_gen;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [5:0]  link_id;
  logic        abort;
  logic [15:0] waddr;
  logic [15:0] id_jump;
  logic        itl_vld;
  logic        itl_last;
  logic        itl_rdy;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] itl_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itl_addr_gen dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .link_id  (link_id),
    .abort    (abort),
    .waddr    (waddr),
    .id_jump  (id_jump),
    .itl_vld  (itl_vld),
    .itl_last (itl_last),
    .itl_rdy  (itl_rdy),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Odd multiplier keeps every ROM word distinct, so any skipped or
  // repeated address shows up as a data error.
  function automatic logic [15:0] rom_val(input logic [15:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'd40503;
    return p[15:0] ^ 16'h5a5a;
  endfunction

  // Registered ROM read, held while the consumer stalls a valid entry.
  always @(posedge clk) begin
    if (!itl_vld || itl_rdy) itl_addr <= rom_val(waddr + id_jump);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one start request from the post-edge point; returns at the
  // post-edge point after the block (or rejection) completes.
  task automatic run_block(input logic [5:0] id, input bit exp_err, input int exp_len,
                           input int exp_base, input bit rnd, input string nm);
    int n, hs, bad, done_early, last_n, max_sum;
    bit prev_stall;
    logic [15:0] held_addr, held_waddr;
    logic [16:0] sum;
    logic rdy;
    start = 1'b1;
    link_id = id;
    itl_rdy = 1'b1;
    tick();
    start = 1'b0;
    if (exp_err) begin
      check({nm, "_busy"}, busy, 0);
      check({nm, "_err"}, err, 1);
      check({nm, "_vld0"}, itl_vld, 0);
      tick();
      check({nm, "_err_pulse"}, err, 0);
      check({nm, "_vld1"}, itl_vld, 0);
      $display("block %s id=%0d rejected err=1", nm, id);
      return;
    end
    check({nm, "_busy"}, busy, 1);
    check({nm, "_waddr0"}, waddr, 0);
    n = 0; hs = 0; bad = 0; done_early = 0; last_n = -1; max_sum = 0;
    prev_stall = 1'b0; held_addr = '0; held_waddr = '0;
    while (hs < exp_len && n < 20000) begin
      if (prev_stall && (itl_addr !== held_addr || waddr !== held_waddr)) bad++;
      if (done) done_early++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      itl_rdy = rdy;
      if (n == 5) begin
        start = 1'b1;
        link_id = 6'd20;
      end
      if (itl_vld && rdy) begin
        if (itl_addr !== rom_val(16'(exp_base + hs)) || itl_last !== (hs == exp_len - 1)) begin
          if (bad == 0)
            $display("  %s entry %0d: itl_addr=%0h want %0h last=%0b", nm, hs, itl_addr,
                     rom_val(16'(exp_base + hs)), itl_last);
          bad++;
        end
        last_n = n;
        hs++;
      end
      prev_stall = itl_vld && !rdy;
      held_addr = itl_addr;
      held_waddr = waddr;
      sum = {1'b0, waddr} + {1'b0, id_jump};
      if (int'(sum) > max_sum) max_sum = int'(sum);
      tick();
      start = 1'b0;
      n++;
    end
    itl_rdy = 1'b1;
    check({nm, "_handshakes"}, hs, exp_len);
    check({nm, "_seq_bad"}, bad, 0);
    check({nm, "_done_early"}, done_early, 0);
    check({nm, "_id_jump"}, id_jump, exp_base);
    check({nm, "_last_waddr"}, waddr, exp_len - 1);
    check({nm, "_max_rom_addr"}, max_sum, exp_base + exp_len - 1);
    check({nm, "_done"}, done, 1);
    check({nm, "_busy_fall"}, busy, 0);
    check({nm, "_vld_clear"}, itl_vld, 0);
    if (!rnd) check({nm, "_last_cycle"}, last_n, exp_len);
    $display("block %s id=%0d entries=%0d base=%0d cycles=%0d", nm, id, hs, id_jump, n + 1);
    tick();
    check({nm, "_done_pulse"}, done, 0);
  endtask

  typedef struct {
    logic [5:0] id;
    bit         exp_err;
    int         len;
    int         base;
    bit         rnd;
    string      nm;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k, dseen;
    vecs[0] = '{6'd20, 1'b0, 96,   24132, 1'b0, "id20"};
    vecs[1] = '{6'd4,  1'b0, 952,  0,     1'b1, "id4_rand"};
    vecs[2] = '{6'd3,  1'b1, 0,    0,     1'b0, "id3"};
    vecs[3] = '{6'd30, 1'b1, 0,    0,     1'b0, "id30"};
    vecs[4] = '{6'd34, 1'b1, 0,    0,     1'b0, "id34"};
    vecs[5] = '{6'd29, 1'b0, 5552, 57960, 1'b0, "id29"};
    vecs[6] = '{6'd12, 1'b0, 972,  4744,  1'b1, "id12_rand"};
    vecs[7] = '{6'd63, 1'b1, 0,    0,     1'b0, "id63"};

    n_rst = 1'b0; start = 1'b0; link_id = '0; abort = 1'b0; itl_rdy = 1'b1;
    #1;
    check("rst_waddr", waddr, 0);
    check("rst_id_jump", id_jump, 0);
    check("rst_vld", {itl_vld, itl_last}, 0);
    check("rst_flags", {busy, done, err}, 0);
    #20;
    @(negedge clk) n_rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_block(vecs[i].id, vecs[i].exp_err, vecs[i].len, vecs[i].base, vecs[i].rnd, vecs[i].nm);

    // Abort mid-block, with a simultaneous start that must lose.
    start = 1'b1; link_id = 6'd8; itl_rdy = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (waddr != 16'd100 && k < 500) begin
      tick();
      k++;
    end
    check("abort_reach_100", waddr, 100);
    abort = 1'b1; start = 1'b1; link_id = 6'd5;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_vld", {itl_vld, itl_last}, 0);
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) dseen++;
      tick();
    end
    check("abort_no_done", dseen, 0);
    $display("abort id=8 at waddr=100 busy=%0b itl_vld=%0b", busy, itl_vld);
    run_block(6'd5, 1'b0, 288, 952, 1'b0, "id5_after_abort");

    // Asynchronous reset while stalled mid-block.
    start = 1'b1; link_id = 6'd8; itl_rdy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_stalled", {busy, itl_vld}, 2'b11);
    @(negedge clk) n_rst = 1'b0;
    #1;
    check("midrst_waddr", waddr, 0);
    check("midrst_id_jump", id_jump, 0);
    check("midrst_vld", {itl_vld, itl_last}, 0);
    check("midrst_flags", {busy, done, err}, 0);
    $display("mid-block reset busy=%0b itl_vld=%0b waddr=%0d", busy, itl_vld, waddr);
    @(negedge clk) n_rst = 1'b1;
    tick();
    run_block(6'd8, 1'b0, 192, 2968, 1'b0, "id8_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
